distance_display: RTL and testbench

Downstream consumer of the ultrasonic ranging block. Periodically snapshots the 33-bit centimetre distance and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. Drives four active-low seven-segment digits (HEX3..HEX0) with leading-zero blanking and an over-range indication. The update rate is throttled so the displayed value does not flicker while the sensor re-measures every 50 ms.

---
 rtl/distance_display.sv | 138 +++++++++++++
 tb/tb_distance_display.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/distance_display.sv
// Snapshots a centimetre distance at a throttled rate, converts it to four BCD
// digits with a sequential double-dabble engine and drives active-low 7-segment digits.
module distance_display #(
  parameter int UPDATE_CYCLES = 12_500_000,
  parameter int IN_W          = 33
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IN_W-1:0] distance,
  output logic [6:0]      hex0,
  output logic [6:0]      hex1,
  output logic [6:0]      hex2,
  output logic [6:0]      hex3,
  output logic            overflow,
  output logic            busy
);

  localparam int         DIV_W    = $clog2(UPDATE_CYCLES);
  localparam int         BIN_W    = 14;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CONVERT,
    COMMIT
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [BIN_W-1:0]   bin_sr;
  logic [15:0]        bcd;
  logic [15:0]        bcd_adj;
  logic [3:0]         bit_cnt;
  logic               ovf_pending;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  assign tick = (div_cnt == DIV_W'(UPDATE_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset || tick) div_cnt <= '0;
    else               div_cnt <= div_cnt + DIV_W'(1);
  end

  // Add-3 correction: each nibble is adjusted independently, carries never cross nibbles.
  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      bin_sr      <= '0;
      bcd         <= '0;
      bit_cnt     <= '0;
      ovf_pending <= 1'b0;
      overflow    <= 1'b0;
      hex0        <= SEG_ZERO;
      hex1        <= SEG_BLANK;
      hex2        <= SEG_BLANK;
      hex3        <= SEG_BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (distance > IN_W'(9999)) begin
            ovf_pending <= 1'b1;
            state       <= COMMIT;
          end else begin
            ovf_pending <= 1'b0;
            bin_sr      <= distance[BIN_W-1:0];
            bcd         <= '0;
            bit_cnt     <= '0;
            state       <= CONVERT;
          end
        end
        CONVERT: begin
          bcd     <= {bcd_adj[14:0], bin_sr[BIN_W-1]};
          bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'(BIN_W - 1)) state <= COMMIT;
        end
        COMMIT: begin
          if (ovf_pending) begin
            overflow <= 1'b1;
            hex0     <= SEG_DASH;
            hex1     <= SEG_DASH;
            hex2     <= SEG_DASH;
            hex3     <= SEG_DASH;
          end else begin
            overflow <= 1'b0;
            hex0     <= seg_decode(bcd[3:0]);
            hex1     <= (bcd[15:4]  == '0) ? SEG_BLANK : seg_decode(bcd[7:4]);
            hex2     <= (bcd[15:8]  == '0) ? SEG_BLANK : seg_decode(bcd[11:8]);
            hex3     <= (bcd[15:12] == '0) ? SEG_BLANK : seg_decode(bcd[15:12]);
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_distance_display.sv
// Randomized self-checking bench for distance_display; expected digits come from
// decimal arithmetic on the snapshot value, timing from the documented cycle budget.
module tb_distance_display;

  localparam int         UPD       = 64;
  localparam logic [6:0] BLANK     = 7'b1111111;
  localparam logic [6:0] DASH      = 7'b0111111;
  localparam logic [28:0] RESET_OUT = {BLANK, BLANK, BLANK, 7'b1000000, 1'b0};

  logic        clock = 1'b0;
  logic        reset;
  logic [32:0] distance;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic        overflow, busy;
  logic [28:0] dut_out;
  logic [28:0] exp_out;

  int errors = 0;
  int checks = 0;

  distance_display #(.UPDATE_CYCLES(UPD), .IN_W(33)) dut (
    .clock    (clock),
    .reset    (reset),
    .distance (distance),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clock = ~clock;
  assign dut_out = {hex3, hex2, hex1, hex0, overflow};

  function automatic logic [6:0] seg(input int d);
    logic [6:0] tab [10];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tab[d];
  endfunction

  // Display image {hex3,hex2,hex1,hex0,overflow} for a captured distance.
  function automatic logic [28:0] model(input logic [32:0] d);
    longint v;
    logic [6:0] h3, h2, h1, h0;
    v = longint'(d);
    if (v > 9999) return {DASH, DASH, DASH, DASH, 1'b1};
    h3 = (v >= 1000) ? seg(int'(v / 1000))        : BLANK;
    h2 = (v >= 100)  ? seg(int'((v / 100) % 10))  : BLANK;
    h1 = (v >= 10)   ? seg(int'((v / 10) % 10))   : BLANK;
    h0 = seg(int'(v % 10));
    return {h3, h2, h1, h0, 1'b0};
  endfunction

  task automatic wait_busy(input string name, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 200) begin
      @(negedge clock);
      n++;
      if (busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_start: busy never rose within %0d cycles, required rise", name, n);
    end
  endtask

  // Called at the negedge of the LOAD cycle; follows the conversion to its commit.
  task automatic finish_snapshot(input logic [32:0] d, input int change_at,
                                 input logic [32:0] d2, input string name);
    int          n = 0;
    bit          stable = 1'b1;
    logic [28:0] bad = '0;
    int          want_len;
    want_len = (d > 33'd9999) ? 2 : 16;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (stable && dut_out !== exp_out) begin
        stable = 1'b0;
        bad    = dut_out;
      end
      if (n == change_at) distance = d2;
      @(negedge clock);
    end
    checks++;
    if (n !== want_len) begin
      errors++;
      $display("FAIL %s_busy_len: got %0d cycles, required %0d", name, n, want_len);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL %s_hold: outputs moved before commit to %h, required %h", name, bad, exp_out);
    end
    exp_out = model(d);
    checks++;
    if (dut_out !== exp_out) begin
      errors++;
      $display("FAIL %s_value (d=%0d): got %h, required %h", name, d, dut_out, exp_out);
    end
  endtask

  task automatic snapshot(input logic [32:0] d, input int change_at,
                          input logic [32:0] d2, input string name);
    bit ok;
    distance = d;
    wait_busy(name, ok);
    if (ok) finish_snapshot(d, change_at, d2, name);
  endtask

  // Counts edges from the reset edge to the first LOAD while the display must hold.
  task automatic count_to_first_load(input string name);
    int n = 0;
    bit stable = 1'b1;
    while (n < 200) begin
      @(negedge clock);
      n++;
      if (busy === 1'b1) break;
      if (dut_out !== RESET_OUT) stable = 1'b0;
    end
    checks++;
    if (n !== UPD) begin
      errors++;
      $display("FAIL %s_first_tick: got busy after %0d cycles, required %0d", name, n, UPD);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL %s_idle_hold: outputs left reset image, got %h required %h", name, dut_out, RESET_OUT);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    distance = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    exp_out = RESET_OUT;
    checks++;
    if (dut_out !== RESET_OUT || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got %h busy=%b, required %h busy=0", dut_out, busy, RESET_OUT);
    end
    count_to_first_load("reset");
    finish_snapshot(33'd0, -1, 33'd0, "reset_zero");
  endtask

  task automatic test_digits();
    snapshot(33'd1234,  -1, 33'd0, "d1234");
    snapshot(33'd7,     -1, 33'd0, "d7");
    snapshot(33'd105,   -1, 33'd0, "d105");
    snapshot(33'd9999,  -1, 33'd0, "d9999");
    snapshot(33'd10000, -1, 33'd0, "d10000");
    snapshot(33'd42,    -1, 33'd0, "d42");
    snapshot(33'h1_0000_0000 | 33'd500, -1, 33'd0, "d_high_bits");
    snapshot(33'd16384, -1, 33'd0, "d16384");
  endtask

  task automatic test_mid_change();
    snapshot(33'd500, 4, 33'd8, "mid_500");
    snapshot(33'd8,  -1, 33'd0, "mid_8");
  endtask

  task automatic test_reset_abort();
    bit ok;
    distance = 33'd3333;
    wait_busy("abort", ok);
    if (!ok) return;
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_out = RESET_OUT;
    checks++;
    if (dut_out !== RESET_OUT || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got %h busy=%b, required %h busy=0", dut_out, busy, RESET_OUT);
    end
    count_to_first_load("abort");
    finish_snapshot(33'd3333, -1, 33'd0, "abort_resume");
  endtask

  task automatic test_random();
    logic [63:0] r;
    logic [32:0] d, d2;
    int          chg;
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0:       d = 33'($urandom_range(0, 9999));
        1:       d = 33'($urandom_range(0, 99));
        2:       d = 33'($urandom_range(9990, 10010));
        default: begin
          r = {$urandom, $urandom};
          d = r[32:0];
        end
      endcase
      r   = {$urandom, $urandom};
      d2  = r[32:0];
      chg = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(2, 14));
      snapshot(d, chg, d2, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    distance = '0;
    exp_out  = RESET_OUT;
    test_reset();
    test_digits();
    test_mid_change();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
